// File: rtl/doodlejump_soc_hex_pkg.sv
// doodlejump_soc_hex_pkg: shared types, widths and BCD helper for the hex score controller
package doodlejump_soc_hex_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;
    typedef enum logic {SCORE, DBG} grant_t;
    localparam int BIN_W = 14;
    localparam int BCD_W = 16;
    localparam int ITERS = 14;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_W / 4; i++)
            r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/doodlejump_soc_hex_score_ctrl_if.sv
// doodlejump_soc_hex_score_ctrl_if: request handshakes and Avalon PIO write bus
interface doodlejump_soc_hex_score_ctrl_if;
    logic        score_valid;
    logic [13:0] score_bin;
    logic        score_ready;
    logic        dbg_valid;
    logic [15:0] dbg_data;
    logic        dbg_ready;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic        busy;

    modport slave (
        input  score_valid, score_bin, dbg_valid, dbg_data,
        output score_ready, dbg_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata, busy
    );
    modport master (
        output score_valid, score_bin, dbg_valid, dbg_data,
        input  score_ready, dbg_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata, busy
    );
endinterface

// File: rtl/doodlejump_soc_bin2bcd_seq.sv
// doodlejump_soc_bin2bcd_seq: sequential 14-bit binary to 4-digit BCD converter (double dabble)
module doodlejump_soc_bin2bcd_seq
    import doodlejump_soc_hex_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);
    logic [BIN_W-1:0] shift;
    logic [3:0]       cnt;

    // Load performs the first iteration (BCD is zero, so only a shift); the rest follow one per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift <= '0;
            bcd   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= !start && cnt == 4'd1;
            if (start) begin
                bcd   <= {{(BCD_W-1){1'b0}}, bin[BIN_W-1]};
                shift <= {bin[BIN_W-2:0], 1'b0};
                cnt   <= 4'(ITERS - 1);
            end else if (cnt != 4'd0) begin
                {bcd, shift} <= {add3(bcd), shift} << 1;
                cnt          <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: rtl/doodlejump_soc_hex_score_ctrl.sv
// doodlejump_soc_hex_score_ctrl: arbitrates score/debug requests and writes hex digits to a PIO
module doodlejump_soc_hex_score_ctrl
    import doodlejump_soc_hex_pkg::*;
#(
    parameter int PIO_ADDR  = 0,
    parameter int SCORE_MAX = 9999
) (
    input logic clk,
    input logic reset_n,
    doodlejump_soc_hex_score_ctrl_if.slave bus
);
    localparam logic [1:0]       ADDR = 2'(PIO_ADDR);
    localparam logic [BIN_W-1:0] SMAX = BIN_W'(SCORE_MAX);

    state_t           state;
    grant_t           last_grant;
    logic             score_go, dbg_go, conv_done;
    logic [BIN_W-1:0] sat;
    logic [BCD_W-1:0] conv_bcd;

    assign bus.score_ready = reset_n && state == IDLE && !(bus.dbg_valid && last_grant == SCORE);
    assign bus.dbg_ready   = reset_n && state == IDLE && !(bus.score_valid && last_grant == DBG);
    assign bus.busy        = state != IDLE;
    assign score_go        = bus.score_valid && bus.score_ready;
    assign dbg_go          = bus.dbg_valid && bus.dbg_ready;
    assign sat             = bus.score_bin > SMAX ? SMAX : bus.score_bin;

    doodlejump_soc_bin2bcd_seq u_conv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (score_go),
        .bin     (sat),
        .bcd     (conv_bcd),
        .done    (conv_done)
    );

    // Control FSM with registered Avalon outputs, set on entry to WRITE and cleared on exit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            last_grant         <= DBG;
            bus.avm_address    <= ADDR;
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_writedata  <= '0;
        end else begin
            bus.avm_address <= ADDR;
            case (state)
                IDLE: begin
                    if (score_go) begin
                        state      <= CONVERT;
                        last_grant <= SCORE;
                    end else if (dbg_go) begin
                        state              <= WRITE;
                        last_grant         <= DBG;
                        bus.avm_chipselect <= 1'b1;
                        bus.avm_write_n    <= 1'b0;
                        bus.avm_writedata  <= {16'b0, bus.dbg_data};
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        state              <= WRITE;
                        bus.avm_chipselect <= 1'b1;
                        bus.avm_write_n    <= 1'b0;
                        bus.avm_writedata  <= {16'b0, conv_bcd};
                    end
                end
                WRITE: begin
                    state              <= IDLE;
                    bus.avm_chipselect <= 1'b0;
                    bus.avm_write_n    <= 1'b1;
                    bus.avm_writedata  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_doodlejump_soc_hex_score_ctrl.sv
// tb_doodlejump_soc_hex_score_ctrl: directed and randomized checks against an arithmetic reference model
module tb_doodlejump_soc_hex_score_ctrl;
    localparam int SCORE_MAX = 9999;

    logic clk, reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] wq_data[$];
    int          wq_stamp[$];

    doodlejump_soc_hex_score_ctrl_if bus ();

    doodlejump_soc_hex_score_ctrl #(.PIO_ADDR(0), .SCORE_MAX(SCORE_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: saturate, then take decimal digits with plain arithmetic
    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = v > SCORE_MAX ? SCORE_MAX : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Record every write strobe with the cycle it occupies (cycle after the last edge)
    always @(negedge clk) begin
        if (bus.avm_chipselect && !bus.avm_write_n) begin
            wq_data.push_back(bus.avm_writedata);
            wq_stamp.push_back(cyc + 1);
            chk("wr_addr", {30'b0, bus.avm_address}, 32'd0);
        end
    end

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (wq_data.size() < n && k < budget);
        chk("write_timeout", 32'(wq_data.size() >= n), 32'd1);
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One request alone on the bus: checks data and latency from acceptance
    task automatic do_req(input bit is_dbg, input logic [15:0] val, output int t);
        int n0, k;
        logic [31:0] e;
        n0 = wq_data.size();
        @(negedge clk);
        if (is_dbg) begin bus.dbg_valid = 1'b1; bus.dbg_data = val; end
        else begin bus.score_valid = 1'b1; bus.score_bin = val[13:0]; end
        #1;
        k = 0;
        while (!(is_dbg ? bus.dbg_ready : bus.score_ready) && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("accept_timeout", 32'(k < 50), 32'd1);
        t = cyc + 1;
        @(posedge clk); #1;
        bus.score_valid = 1'b0;
        bus.dbg_valid   = 1'b0;
        bus.score_bin   = 14'($urandom);
        bus.dbg_data    = 16'($urandom);
        e = is_dbg ? {16'h0, val} : {16'h0, to_bcd(int'(val[13:0]))};
        wait_writes(n0 + 1, 40);
        if (wq_data.size() > n0) begin
            chk(is_dbg ? "dbg_data" : "score_data", wq_data[n0], e);
            chk(is_dbg ? "dbg_latency" : "score_latency", 32'(wq_stamp[n0]), 32'(t + (is_dbg ? 1 : 15)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t, n0, bad, score_cnt;
        bit lg_dbg;
        logic [31:0] e;
        reset_n = 1'b0;
        bus.score_valid = 1'b0;
        bus.score_bin   = '0;
        bus.dbg_valid   = 1'b0;
        bus.dbg_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'b0, bus.avm_chipselect}, 32'd0);
        chk("rst_wn", {31'b0, bus.avm_write_n}, 32'd1);
        chk("rst_wd", bus.avm_writedata, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_addr", {30'b0, bus.avm_address}, 32'd0);
        reset_n = 1'b1;

        // Idle for 100 cycles with no strobe
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 ||
                bus.avm_writedata !== 32'd0 || bus.busy !== 1'b0) bad++;
        end
        chk("idle_outputs", 32'(bad), 32'd0);
        chk("idle_no_write", 32'(wq_data.size()), 32'd0);

        do_req(1'b0, 16'd1234, t);
        chk("score_1234", wq_data[wq_data.size()-1], 32'h0000_1234);
        do_req(1'b0, 16'd12000, t);
        do_req(1'b0, 16'd0, t);
        do_req(1'b0, 16'd9999, t);
        chk("score_9999", wq_data[wq_data.size()-1], 32'h0000_9999);

        // Debug latency and ready reassertion
        do_req(1'b1, 16'hA5C3, t);
        chk("dbg_ready_in_write", {31'b0, bus.dbg_ready}, 32'd0);
        @(negedge clk); #1;
        chk("dbg_ready_cycle", 32'(cyc + 1), 32'(t + 2));
        chk("dbg_ready_again", {31'b0, bus.dbg_ready}, 32'd1);

        // A valid raised while busy and dropped before acceptance writes nothing
        n0 = wq_data.size();
        @(negedge clk);
        bus.score_valid = 1'b1; bus.score_bin = 14'd300;
        @(posedge clk); #1;
        bus.score_valid = 1'b0;
        bus.dbg_valid = 1'b1; bus.dbg_data = 16'hDEAD;
        repeat (3) @(negedge clk);
        bus.dbg_valid = 1'b0;
        repeat (25) @(negedge clk);
        chk("withdrawn_count", 32'(wq_data.size()), 32'(n0 + 1));
        chk("withdrawn_data", wq_data[wq_data.size()-1], 32'h0000_0300);

        // Both held from reset: round robin starting with the score
        reset_dut(2);
        n0 = wq_data.size();
        @(negedge clk);
        bus.score_valid = 1'b1; bus.score_bin = 14'd42;
        bus.dbg_valid = 1'b1; bus.dbg_data = 16'hBEEF;
        wait_writes(n0 + 4, 100);
        bus.score_valid = 1'b0;
        bus.dbg_valid = 1'b0;
        lg_dbg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = lg_dbg ? {16'h0, to_bcd(42)} : 32'h0000_BEEF;
            lg_dbg = !lg_dbg;
            if (wq_data.size() > n0 + i) chk("rr_order", wq_data[n0 + i], e);
        end
        repeat (20) @(negedge clk);
        chk("rr_count", 32'(wq_data.size()), 32'(n0 + 4));

        // Reset mid-conversion aborts the write; no handshake while reset is held
        reset_dut(2);
        n0 = wq_data.size();
        @(negedge clk);
        bus.score_valid = 1'b1; bus.score_bin = 14'd5678;
        @(posedge clk); #1;
        bus.score_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        bus.score_valid = 1'b1;
        #1;
        chk("rst_no_ready", {31'b0, bus.score_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_busy_mid", {31'b0, bus.busy}, 32'd0);
        bus.score_valid = 1'b0;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_write", 32'(wq_data.size()), 32'(n0));
        do_req(1'b0, 16'd77, t);
        repeat (3) @(negedge clk);
        chk("after_abort_count", 32'(wq_data.size()), 32'(n0 + 1));

        // Randomized single requests against the model
        score_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            n0 = wq_data.size();
            if ($urandom_range(0, 1) == 1) do_req(1'b1, 16'($urandom), t);
            else begin
                do_req(1'b0, {2'b0, 14'($urandom_range(0, 16383))}, t);
                score_cnt++;
            end
            repeat (2) @(negedge clk);
            chk("rand_count", 32'(wq_data.size()), 32'(n0 + 1));
        end
        chk("rand_idle", {31'b0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/doodlejump_soc_hex_score_ctrl.md
DOODLEJUMP_SOC_HEX_SCORE_CTRL -- requirements
Module: doodlejump_soc_hex_score_ctrl

Interface
REQ-001 SHALL have parameter PIO_ADDR, default 0, meaning the PIO register address driven on avm_address.
REQ-002 SHALL have parameter SCORE_MAX, default 9999, meaning the saturation limit for binary scores.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 score_valid  input  1  score request pending.
REQ-006 score_bin  input  14  unsigned binary score.
REQ-007 score_ready  output  1  score request accepted when score_valid && score_ready.
REQ-008 dbg_valid  input  1  raw debug pattern request pending.
REQ-009 dbg_data  input  16  raw 4-nibble hex pattern, written unconverted.
REQ-010 dbg_ready  output  1  debug request accepted when dbg_valid && dbg_ready.
REQ-011 avm_address  output  2  PIO register address.
REQ-012 avm_chipselect  output  1  PIO select.
REQ-013 avm_write_n  output  1  PIO write strobe, active low.
REQ-014 avm_writedata  output  32  PIO write data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, CONVERT, WRITE.
REQ-017 In IDLE: score_ready = !(dbg_valid && last_grant==SCORE); dbg_ready = !(score_valid && last_grant==DBG); both are 0 outside IDLE.
REQ-018 When both requests are valid in IDLE, the requester not named by last_grant SHALL be accepted (round robin); last_grant SHALL update on every acceptance.
REQ-019 Score acceptance: the value is latched, saturated to SCORE_MAX if larger, and the FSM goes IDLE->CONVERT.
REQ-020 CONVERT SHALL perform 14 shift-add-3 (double dabble) iterations, one per cycle, producing 4 BCD nibbles, then go to WRITE.
REQ-021 Debug acceptance: dbg_data is latched and the FSM goes IDLE->WRITE directly.
REQ-022 WRITE SHALL last exactly one cycle: avm_chipselect=1, avm_write_n=0, avm_address=PIO_ADDR, avm_writedata={16'b0, value}; then the FSM returns to IDLE.
REQ-023 Outside WRITE: avm_chipselect=0, avm_write_n=1, avm_writedata=0; all avm_* outputs are registered.
REQ-024 Latency, accept at edge T: score write strobe during cycle T+15; debug write strobe during cycle T+1; ready may reassert in the cycle after the strobe.
REQ-025 Exactly one PIO write SHALL occur per accepted request; requests are never dropped or merged.
REQ-026 Input changes while busy SHALL not affect the conversion or write in flight.
REQ-027 A valid deasserted before acceptance SHALL cause no write.

Reset
REQ-028 While reset_n=0: state=IDLE, last_grant=DBG, avm_chipselect=0, avm_write_n=1, avm_address=PIO_ADDR, avm_writedata=0, busy=0, latched data and BCD registers cleared.
REQ-029 Reset asserted mid-CONVERT or mid-WRITE SHALL abort the operation with no write after reset release; the aborted request is not retried.
REQ-030 No handshake SHALL complete while reset_n=0.

Structure
REQ-031 The FSM state enum, the grant enum (SCORE/DBG), the BCD width (16) and the iteration count (14) SHALL live in the shared package doodlejump_soc_hex_pkg.
REQ-032 The conversion SHALL be the sub-module doodlejump_soc_bin2bcd_seq (start/done handshake, 14-bit in, 16-bit BCD out); arbitration and the Avalon driving logic SHALL stay in the top module.

Verification
REQ-033 Reset, no requests -> chipselect=0, write_n=1, writedata=0x00000000, busy=0, with no strobe for 100 cycles.
REQ-034 score_bin=1234 accepted at T -> single strobe at T+15, address 0, writedata=0x00001234.
REQ-035 score_bin=12000, then 0, then 9999 -> writedata 0x00009999, 0x00000000, 0x00009999.
REQ-036 From reset, score_valid (score_bin=42) and dbg_valid (dbg_data=0xBEEF) both held -> strobe order 0x00000042, 0x0000BEEF, 0x00000042, 0x0000BEEF.
REQ-037 Score 5678 accepted, reset_n pulsed low 5 cycles later, then score 0077 -> no 0x5678 write; one strobe with writedata=0x00000077.
REQ-038 Debug 0xA5C3 accepted at T -> strobe at T+1, writedata=0x0000A5C3; dbg_ready high again at T+2.
